// File: rtl/shader_dispatch_pipeline.sv
// Shader front end: request FIFO, per-pixel mode latch, coordinate normalisation, one vector op per pixel, RGB888 out.
// Optional macro SHADER_TIMEOUT_EN adds a WAIT-state watchdog that forces a magenta pixel and sets err_timeout.
module shader_dispatch_pipeline #(
   parameter int DATA_WIDTH     = 16,
   parameter int VECTOR_WIDTH   = 4,
   parameter int COORD_WIDTH    = 10,
   parameter int FIFO_DEPTH     = 4,
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int CHECKER_SHIFT  = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [COORD_WIDTH-1:0]               pixel_x,
   input  logic [COORD_WIDTH-1:0]               pixel_y,
   input  logic [3:0]                           shader_select,
   input  logic [23:0]                          cfg_color,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [7:0]                           red_out,
   output logic [7:0]                           green_out,
   output logic [7:0]                           blue_out,
   output logic                                 vp_start,
   output logic [3:0]                           vp_operation,
   output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_vec_a,
   output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_vec_b,
   output logic [DATA_WIDTH-1:0]                vp_scalar,
   input  logic                                 vp_busy,
   input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_result,
   input  logic                                 vp_result_valid,
   output logic                                 err_timeout
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = 2*COORD_WIDTH + 4;
   localparam int VEC_W   = VECTOR_WIDTH*DATA_WIDTH;
   localparam logic [DATA_WIDTH-1:0] K_FF00 = DATA_WIDTH'(16'hFF00);
   localparam logic [DATA_WIDTH-1:0] K_8000 = DATA_WIDTH'(16'h8000);
   localparam logic [DATA_WIDTH-1:0] K_4000 = DATA_WIDTH'(16'h4000);
   localparam logic [DATA_WIDTH-1:0] K_C000 = DATA_WIDTH'(16'hC000);
   localparam logic [DATA_WIDTH-1:0] K_0100 = DATA_WIDTH'(16'h0100);
   localparam logic [DATA_WIDTH-1:0] K_0080 = DATA_WIDTH'(16'h0080);
   localparam logic [DATA_WIDTH-1:0] K_00FF = DATA_WIDTH'(16'h00FF);

   typedef enum logic [2:0] {ST_IDLE, ST_NORM, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

   state_t                   r_state;
   logic [ENTRY_W-1:0]       r_fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]         r_wrPtr, r_rdPtr;
   logic [PTR_W:0]           r_count;
   logic                     r_inReady;
   logic [15:0]              r_frameCnt, r_timeVar;
   logic [COORD_WIDTH-1:0]   r_x, r_y;
   logic [3:0]               r_sel;
   logic [DATA_WIDTH-1:0]    r_normX, r_normY, r_centerX, r_centerY;
   logic                     r_vpStart, r_outValid;
   logic [3:0]               r_vpOp;
   logic [VEC_W-1:0]         r_vpVecA;
   logic [DATA_WIDTH-1:0]    r_vpScalar;
   logic [7:0]               r_red, r_green, r_blue;

   logic                     w_push, w_pop;
   logic [PTR_W:0]           w_countNext;
   logic [ENTRY_W-1:0]       w_head;
   logic [DATA_WIDTH-1:0]    w_normX, w_normY, w_scalar, w_t;
   logic [DATA_WIDTH-1:0]    w_lane [4];
   logic [VEC_W-1:0]         w_vecA;
   logic [3:0]               w_op;
   logic [DATA_WIDTH-1:0]    w_res3, w_res2, w_res1;
   logic                     w_unused;

   assign w_push  = in_valid && r_inReady;
   assign w_pop   = (r_state == ST_IDLE) && (r_count != '0);
   assign w_head  = r_fifoMem[r_rdPtr];
   assign w_normX = DATA_WIDTH'((32'(r_x) * 32'd256) / 32'(SCREEN_W));
   assign w_normY = DATA_WIDTH'((32'(r_y) * 32'd256) / 32'(SCREEN_H));
   assign w_t     = (r_normX + DATA_WIDTH'(r_timeVar)) & K_00FF;
   assign w_res3  = vp_result[3*DATA_WIDTH +: DATA_WIDTH];
   assign w_res2  = vp_result[2*DATA_WIDTH +: DATA_WIDTH];
   assign w_res1  = vp_result[1*DATA_WIDTH +: DATA_WIDTH];
   assign w_unused = ^{vp_result[DATA_WIDTH-1:0], w_res3[DATA_WIDTH-9:0], w_res2[DATA_WIDTH-9:0],
                       w_res1[DATA_WIDTH-9:0], r_normY != '0, TIMEOUT_CYCLES != 0};

   always_comb begin
      w_countNext = r_count;
      if (w_push && !w_pop)
         w_countNext = r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop)
         w_countNext = r_count - (PTR_W+1)'(1);
   end

   // Operand selection per latched mode; lane 3 is the top lane (red), lane 0 alpha.
   always_comb begin
      w_op     = 4'h4;
      w_scalar = K_0100;
      w_lane   = '{K_FF00, K_C000, K_4000, K_8000};
      case (r_sel)
         4'd0: begin w_lane = '{K_FF00, '0, '0, K_FF00}; w_scalar = r_normX; end
         4'd1: begin w_lane = '{K_FF00, '0, K_FF00, '0}; w_scalar = r_normY; end
         4'd2: begin w_op = 4'h5; w_lane = '{'0, '0, r_centerY, r_centerX}; end
         4'd3: begin
            w_lane   = '{K_FF00, K_FF00, K_FF00, K_FF00};
            w_scalar = (r_x[CHECKER_SHIFT] ^ r_y[CHECKER_SHIFT]) ? K_0100 : '0;
         end
         4'd4: w_lane = '{K_FF00, w_t, K_8000, w_t};
         4'd5: w_lane = '{K_FF00, DATA_WIDTH'({cfg_color[7:0], 8'h00}),
                          DATA_WIDTH'({cfg_color[15:8], 8'h00}), DATA_WIDTH'({cfg_color[23:16], 8'h00})};
         default: ;
      endcase
      w_vecA = '0;
      for (int i = 0; i < 4; i++)
         w_vecA[i*DATA_WIDTH +: DATA_WIDTH] = w_lane[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_inReady  <= 1'b0;
         r_frameCnt <= '0;
         r_timeVar  <= '0;
      end else begin
         if (w_push) begin
            r_fifoMem[r_wrPtr] <= {pixel_x, pixel_y, shader_select};
            r_wrPtr            <= r_wrPtr + PTR_W'(1);
            if (pixel_x == '0 && pixel_y == '0) begin
               r_frameCnt <= r_frameCnt + 16'd1;
               r_timeVar  <= {8'h00, r_frameCnt[15:8]};
            end
         end
         if (w_pop)
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         r_count   <= w_countNext;
         r_inReady <= (w_countNext != (PTR_W+1)'(FIFO_DEPTH));
      end
   end

`ifdef SHADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_waitCnt;
   logic            r_errTimeout;
   assign err_timeout = r_errTimeout;
`else
   assign err_timeout = 1'b0;
`endif

   // Strictly in-order dispatch: a new request is only popped once the previous pixel has left OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_sel      <= '0;
         r_normX    <= '0;
         r_normY    <= '0;
         r_centerX  <= '0;
         r_centerY  <= '0;
         r_vpStart  <= 1'b0;
         r_vpOp     <= '0;
         r_vpVecA   <= '0;
         r_vpScalar <= '0;
         r_outValid <= 1'b0;
         r_red      <= '0;
         r_green    <= '0;
         r_blue     <= '0;
`ifdef SHADER_TIMEOUT_EN
         r_waitCnt    <= '0;
         r_errTimeout <= 1'b0;
`endif
      end else begin
         r_vpStart <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_pop) begin
               {r_x, r_y, r_sel} <= w_head;
               r_state           <= ST_NORM;
            end
            ST_NORM: begin
               r_normX   <= w_normX;
               r_normY   <= w_normY;
               r_centerX <= w_normX - K_0080;
               r_centerY <= w_normY - K_0080;
               r_state   <= ST_ISSUE;
            end
            ST_ISSUE: if (!vp_busy) begin
               r_vpStart  <= 1'b1;
               r_vpOp     <= w_op;
               r_vpVecA   <= w_vecA;
               r_vpScalar <= w_scalar;
               r_state    <= ST_WAIT;
`ifdef SHADER_TIMEOUT_EN
               r_waitCnt  <= '0;
`endif
            end
            ST_WAIT: begin
               if (vp_result_valid) begin
                  r_outValid <= 1'b1;
                  r_state    <= ST_OUT;
                  if (r_sel == 4'd2) begin
                     r_red   <= w_res3[DATA_WIDTH-1 -: 8];
                     r_green <= w_res3[DATA_WIDTH-1 -: 8];
                     r_blue  <= 8'hFF - w_res3[DATA_WIDTH-1 -: 8];
                  end else begin
                     r_red   <= w_res3[DATA_WIDTH-1 -: 8];
                     r_green <= w_res2[DATA_WIDTH-1 -: 8];
                     r_blue  <= w_res1[DATA_WIDTH-1 -: 8];
                  end
               end
`ifdef SHADER_TIMEOUT_EN
               else if (r_waitCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_outValid   <= 1'b1;
                  r_state      <= ST_OUT;
                  r_red        <= 8'hFF;
                  r_green      <= 8'h00;
                  r_blue       <= 8'hFF;
                  r_errTimeout <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + TO_W'(1);
               end
`endif
            end
            ST_OUT: if (out_ready) begin
               r_outValid <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready     = r_inReady;
   assign out_valid    = r_outValid;
   assign red_out      = r_red;
   assign green_out    = r_green;
   assign blue_out     = r_blue;
   assign vp_start     = r_vpStart;
   assign vp_operation = r_vpOp;
   assign vp_vec_a     = r_vpVecA;
   assign vp_vec_b     = '0;
   assign vp_scalar    = r_vpScalar;
endmodule

// File: tb/tb_shader_dispatch_pipeline.sv
// Scoreboard bench for shader_dispatch_pipeline: a behavioural vector processor checks each issued op,
// and a colour monitor checks every pixel the DUT presents against hand-computed expectations.
module tb_shader_dispatch_pipeline;
   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [9:0]  pixel_x, pixel_y;
   logic [3:0]  shader_select;
   logic [23:0] cfg_color;
   logic        out_valid, out_ready;
   logic [7:0]  red_out, green_out, blue_out;
   logic        vp_start;
   logic [3:0]  vp_operation;
   logic [63:0] vp_vec_a, vp_vec_b, vp_result;
   logic [15:0] vp_scalar;
   logic        vp_busy, vp_result_valid, err_timeout;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] vecA;
      logic [15:0] scalar;
      logic [63:0] result;
      int          delay;
      bit          respond;
   } vpExp_t;

   vpExp_t      vpQ[$];
   logic [23:0] colQ[$];
   int checks = 0;
   int errors = 0;

   shader_dispatch_pipeline dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .shader_select(shader_select), .cfg_color(cfg_color),
      .out_valid(out_valid), .out_ready(out_ready), .red_out(red_out), .green_out(green_out),
      .blue_out(blue_out), .vp_start(vp_start), .vp_operation(vp_operation), .vp_vec_a(vp_vec_a),
      .vp_vec_b(vp_vec_b), .vp_scalar(vp_scalar), .vp_busy(vp_busy), .vp_result(vp_result),
      .vp_result_valid(vp_result_valid), .err_timeout(err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic vpExp_t makeVp(input logic [3:0] op, input logic [63:0] vecA, input logic [15:0] scalar,
                                     input logic [63:0] result, input bit respond);
      vpExp_t e;
      e.op = op; e.vecA = vecA; e.scalar = scalar; e.result = result; e.delay = 1; e.respond = respond;
      return e;
   endfunction

   // Queue expectations, then hold the request until the DUT accepts it (bounded).
   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [3:0] sel,
                                input vpExp_t e, input bit pushVp, input logic [23:0] col, input bit expectOut);
      bit accepted = 0;
      if (pushVp) vpQ.push_back(e);
      if (expectOut) colQ.push_back(col);
      in_valid = 1'b1; pixel_x = x; pixel_y = y; shader_select = sel;
      for (int i = 0; i < 2000 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            accepted = 1;
         end
      end
      in_valid = 1'b0;
      if (!accepted) begin
         checks++; errors++;
         $display("[TB] FAIL pushAccept: got no acceptance, expected in_ready within 2000 cycles");
      end
   endtask

   task automatic drainWait(input int maxCycles);
      bit done = 0;
      for (int i = 0; i < maxCycles && !done; i++) begin
         @(posedge clk);
         #1;
         done = (colQ.size() == 0) && (vpQ.size() == 0) && !out_valid;
      end
      checkOutput("drainDone", 64'(done), 64'd1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_inReady"}, 64'(in_ready), 64'd0);
      checkOutput({tag, "_outValid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_rgb"}, 64'({red_out, green_out, blue_out}), 64'd0);
      checkOutput({tag, "_vpStart"}, 64'(vp_start), 64'd0);
      checkOutput({tag, "_vpOp"}, 64'(vp_operation), 64'd0);
      checkOutput({tag, "_vpVecA"}, vp_vec_a, 64'd0);
      checkOutput({tag, "_vpScalar"}, 64'(vp_scalar), 64'd0);
      checkOutput({tag, "_err"}, 64'(err_timeout), 64'd0);
   endtask

   // Behavioural vector processor: checks each launch against the queued op and returns the queued result.
   initial begin
      vpExp_t e;
      vp_result_valid = 1'b0;
      vp_result = '0;
      forever begin
         @(negedge clk);
         if (!rst && vp_start) begin
            if (vpQ.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL vpUnexpectedStart: got vp_start=1, expected 0");
            end else begin
               e = vpQ.pop_front();
               checkOutput("vpOperation", 64'(vp_operation), 64'(e.op));
               checkOutput("vpVecA", vp_vec_a, e.vecA);
               checkOutput("vpScalar", 64'(vp_scalar), 64'(e.scalar));
               checkOutput("vpVecB", vp_vec_b, 64'd0);
               if (e.respond) begin
                  repeat (e.delay) @(posedge clk);
                  #1;
                  vp_result = e.result;
                  vp_result_valid = 1'b1;
                  @(negedge clk);
                  checkOutput("vpStartPulse", 64'(vp_start), 64'd0);
                  @(posedge clk);
                  #1;
                  vp_result_valid = 1'b0;
               end else begin
                  @(negedge clk);
                  checkOutput("vpStartPulse", 64'(vp_start), 64'd0);
               end
            end
         end
      end
   end

   // Colour monitor: pops on each accepted pixel; while stalled the held colour must match the head entry.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (colQ.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL outUnexpected: got out_valid=1 rgb=%h, expected no pixel", {red_out, green_out, blue_out});
            end else if (out_ready) begin
               checkOutput("colour", 64'({red_out, green_out, blue_out}), 64'(colQ.pop_front()));
            end else begin
               checkOutput("colourHeld", 64'({red_out, green_out, blue_out}), 64'(colQ[0]));
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got no completion, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int startSeen;
      rst = 1'b1; in_valid = 1'b0; pixel_x = '0; pixel_y = '0; shader_select = '0;
      cfg_color = 24'h123456; out_ready = 1'b1; vp_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("inReadyAfterReset", 64'(in_ready), 64'd1);

      // First pixel: mode 0 at x=320 gives norm_x=0x80, result two cycles after launch.
      applyStimulus(10'd320, 10'd0, 4'd0, makeVp(4'h4, {16'hFF00, 16'h0000, 16'h0000, 16'hFF00}, 16'h0080,
                    {16'h7F80, 16'h0000, 16'h0000, 16'h7F80}, 1), 1, 24'h7F0000, 1);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (out_valid) break;
      end
      checkOutput("latencyEdges", 64'(n), 64'd5);
      drainWait(50);

      // Directed mode sweep, back to back through the FIFO.
      applyStimulus(10'd0, 10'd0, 4'd2, makeVp(4'h5, {16'hFF80, 16'hFF80, 16'h0000, 16'h0000}, 16'h0100,
                    {16'h4000, 16'h0000, 16'h0000, 16'h0000}, 1), 1, 24'h4040BF, 1);
      applyStimulus(10'd32, 10'd0, 4'd3, makeVp(4'h4, {4{16'hFF00}}, 16'h0100,
                    {16'h1234, 16'h5678, 16'h9ABC, 16'h0000}, 1), 1, 24'h12569A, 1);
      applyStimulus(10'd32, 10'd32, 4'd3, makeVp(4'h4, {4{16'hFF00}}, 16'h0000,
                    {16'hFFFF, 16'h0100, 16'h0000, 16'h0000}, 1), 1, 24'hFF0100, 1);
      applyStimulus(10'd100, 10'd240, 4'd1, makeVp(4'h4, {16'h0000, 16'hFF00, 16'h0000, 16'hFF00}, 16'h0080,
                    {16'h0000, 16'h7F80, 16'h0000, 16'h7F80}, 1), 1, 24'h007F00, 1);
      applyStimulus(10'd160, 10'd10, 4'd4, makeVp(4'h4, {16'h0040, 16'h8000, 16'h0040, 16'hFF00}, 16'h0100,
                    {16'hAB00, 16'hCD00, 16'hEF00, 16'h0000}, 1), 1, 24'hABCDEF, 1);
      applyStimulus(10'd3, 10'd4, 4'd5, makeVp(4'h4, {16'h1200, 16'h3400, 16'h5600, 16'hFF00}, 16'h0100,
                    {16'h1200, 16'h3400, 16'h5600, 16'hFF00}, 1), 1, 24'h123456, 1);
      applyStimulus(10'd1, 10'd1, 4'd9, makeVp(4'h4, {16'h8000, 16'h4000, 16'hC000, 16'hFF00}, 16'h0100,
                    {16'h8000, 16'h4000, 16'hC000, 16'hFF00}, 1), 1, 24'h8040C0, 1);
      applyStimulus(10'd5, 10'd5, 4'd15, makeVp(4'h4, {16'h8000, 16'h4000, 16'hC000, 16'hFF00}, 16'h0100,
                    {16'h0100, 16'h0200, 16'h0300, 16'h0000}, 1), 1, 24'h010203, 1);
      applyStimulus(10'd1023, 10'd479, 4'd0, makeVp(4'h4, {16'hFF00, 16'h0000, 16'h0000, 16'hFF00}, 16'h0199,
                    {16'hFF00, 16'h0000, 16'h0000, 16'hFF00}, 1), 1, 24'hFF0000, 1);
      applyStimulus(10'd1023, 10'd479, 4'd1, makeVp(4'h4, {16'h0000, 16'hFF00, 16'h0000, 16'hFF00}, 16'h00FF,
                    {16'h0000, 16'h80FF, 16'h0000, 16'h0000}, 1), 1, 24'h008000, 1);
      applyStimulus(10'd640, 10'd480, 4'd2, makeVp(4'h5, {16'h0080, 16'h0080, 16'h0000, 16'h0000}, 16'h0100,
                    {16'hFF00, 16'h0000, 16'h0000, 16'h0000}, 1), 1, 24'hFFFF00, 1);
      drainWait(300);

      // Backpressure: five back-to-back pushes fill the pipe plus FIFO; order must survive the stall.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         logic [7:0] b0, b1, b2;
         b0 = 8'(16*i + 1); b1 = 8'(16*i + 2); b2 = 8'(16*i + 3);
         applyStimulus(10'(i + 1), 10'd2, 4'd9, makeVp(4'h4, {16'h8000, 16'h4000, 16'hC000, 16'hFF00}, 16'h0100,
                       {b0, 8'h00, b1, 8'h00, b2, 8'h00, 16'h0000}, 1), 1, {b0, b1, b2}, 1);
      end
      checkOutput("inReadyFull", 64'(in_ready), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("inReadyStillFull", 64'(in_ready), 64'd0);
      checkOutput("outValidStalled", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      drainWait(200);

      // Processor busy for ten cycles while the request waits in ISSUE.
      vp_busy = 1'b1;
      applyStimulus(10'd7, 10'd7, 4'd9, makeVp(4'h4, {16'h8000, 16'h4000, 16'hC000, 16'hFF00}, 16'h0100,
                    {16'h5500, 16'h6600, 16'h7700, 16'h0000}, 1), 1, 24'h556677, 1);
      startSeen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (vp_start) startSeen++;
      end
      checkOutput("busyNoStart", 64'(startSeen), 64'd0);
      @(posedge clk);
      #1;
      vp_busy = 1'b0;
      drainWait(50);

      // Reset while waiting on the processor: in-flight pixel and queued requests are dropped.
      applyStimulus(10'd320, 10'd0, 4'd0, makeVp(4'h4, {16'hFF00, 16'h0000, 16'h0000, 16'hFF00}, 16'h0080,
                    64'd0, 0), 1, 24'h0, 0);
      applyStimulus(10'd8, 10'd8, 4'd9, makeVp(4'h0, 64'd0, 16'h0, 64'd0, 0), 0, 24'h0, 0);
      applyStimulus(10'd9, 10'd9, 4'd9, makeVp(4'h0, 64'd0, 16'h0, 64'd0, 0), 0, 24'h0, 0);
      n = 0;
      for (int i = 0; i < 50 && vpQ.size() != 0; i++) begin
         @(posedge clk);
         n++;
      end
      checkOutput("launchBeforeReset", 64'(vpQ.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkAllZero("midReset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("inReadyAfterMidReset", 64'(in_ready), 64'd1);
      startSeen = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (vp_start) startSeen++;
         if (out_valid) n++;
      end
      checkOutput("flushNoStart", 64'(startSeen), 64'd0);
      checkOutput("flushNoOutput", 64'(n), 64'd0);

`ifdef SHADER_TIMEOUT_EN
      applyStimulus(10'd320, 10'd0, 4'd0, makeVp(4'h4, {16'hFF00, 16'h0000, 16'h0000, 16'hFF00}, 16'h0080,
                    64'd0, 0), 1, 24'hFF00FF, 1);
      drainWait(400);
      checkOutput("errTimeoutSet", 64'(err_timeout), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("errTimeoutSticky", 64'(err_timeout), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("errTimeoutCleared", 64'(err_timeout), 64'd0);
`else
      checkOutput("errTimeoutTied", 64'(err_timeout), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
